// File: rtl/config_pkg.sv
// config_pkg: shared UART receiver types and constants for the ALU datapath.
package config_pkg;
    localparam int UART_PRESCALE_W = 16;
    localparam logic [UART_PRESCALE_W-1:0] UART_PRESCALE_MIN = 16'd4;
    localparam int UART_DATA_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs with a parameterized reset value.
module sync_2ff #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= RESET_VAL;
            q_o  <= RESET_VAL;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end
endmodule

// File: rtl/alu_uart_rx.sv
// alu_uart_rx: 8N1 UART receiver with programmable bit period and a one-entry
// valid/ready holding register; flags frame and overrun errors.
module alu_uart_rx import config_pkg::*; #(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       rxd_i,
    input  logic [UART_PRESCALE_W-1:0] prescale_i,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata_o,
    output logic                       m_axis_tvalid_o,
    input  logic                       m_axis_tready_i,
    output logic                       busy_o,
    output logic                       frame_error_o,
    output logic                       overrun_error_o
);
    localparam int IDX_W = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    logic rxd_s, rxd_prev, start_det, tick, deliver;
    uart_rx_state_e state;
    logic [UART_PRESCALE_W-1:0] p_q, cnt, p_clamp;
    logic [IDX_W-1:0] idx;
    logic [DATA_WIDTH-1:0] shreg;

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (rxd_i),
        .q_o   (rxd_s)
    );

    assign p_clamp   = prescale_i < UART_PRESCALE_MIN ? UART_PRESCALE_MIN : prescale_i;
    assign start_det = rxd_prev & ~rxd_s;
    assign tick      = cnt == '0;
    assign deliver   = state == STOP && tick && rxd_s;
    assign busy_o    = state != IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxd_prev        <= 1'b1;
            state           <= IDLE;
            p_q             <= '0;
            cnt             <= '0;
            idx             <= '0;
            shreg           <= '0;
            m_axis_tdata_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
            frame_error_o   <= 1'b0;
            overrun_error_o <= 1'b0;
        end else begin
            rxd_prev        <= rxd_s;
            frame_error_o   <= 1'b0;
            overrun_error_o <= 1'b0;
            // Start detection needs a fresh 1->0 edge, so a line stuck low never re-arms.
            case (state)
                IDLE: if (start_det) begin
                    state <= START;
                    p_q   <= p_clamp;
                    cnt   <= (p_clamp >> 1) - 1'b1;
                end
                START: if (tick) begin
                    state <= rxd_s ? IDLE : DATA;
                    cnt   <= p_q - 1'b1;
                    idx   <= '0;
                end else cnt <= cnt - 1'b1;
                DATA: if (tick) begin
                    shreg[idx] <= rxd_s;
                    cnt        <= p_q - 1'b1;
                    idx        <= idx + 1'b1;
                    if (idx == IDX_W'(DATA_WIDTH - 1)) state <= STOP;
                end else cnt <= cnt - 1'b1;
                STOP: if (tick) begin
                    state         <= IDLE;
                    frame_error_o <= ~rxd_s;
                end else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
            // A full register accepting in the same cycle counts as free.
            if (deliver) begin
                if (!m_axis_tvalid_o || m_axis_tready_i) begin
                    m_axis_tdata_o  <= shreg;
                    m_axis_tvalid_o <= 1'b1;
                end else overrun_error_o <= 1'b1;
            end else if (m_axis_tready_i) m_axis_tvalid_o <= 1'b0;
        end
    end
endmodule
